// File: rtl/fb_cell_scanout_if.sv
// Pixel-side bus between the scanout engine, the cell memory and the display sink.
// The master modport is the scanout engine; the slave modport is the memory/display side.
`timescale 1ns/1ps
interface fb_cell_scanout_if;
   logic [13:0] pixCellIx;
   logic [31:0] cellData1;
   logic [31:0] cellData2;
   logic        scrEnable;
   logic [11:0] fgColor;
   logic [11:0] bgColor;
   logic [11:0] pixRgb;
   logic        pixHsync;
   logic        pixVsync;
   logic        pixDe;
   logic        irqVblank;

   modport master (
      output pixCellIx, pixRgb, pixHsync, pixVsync, pixDe, irqVblank,
      input  cellData1, cellData2, scrEnable, fgColor, bgColor
   );

   modport slave (
      input  pixCellIx, pixRgb, pixHsync, pixVsync, pixDe, irqVblank,
      output cellData1, cellData2, scrEnable, fgColor, bgColor
   );
endinterface

// File: rtl/fb_cell_scanout.sv
// Raster timing plus 8x8 1-bpp cell decode; every output lags the counters by CELL_LAT+2 clocks.
`timescale 1ns/1ps
module fb_cell_scanout #(
   parameter int H_ACTIVE = 320,
   parameter int HS_START = 328,
   parameter int HS_LEN   = 48,
   parameter int H_TOTAL  = 400,
   parameter int V_ACTIVE = 200,
   parameter int VS_START = 212,
   parameter int VS_LEN   = 2,
   parameter int V_TOTAL  = 262,
   parameter int CELLS_X  = 40,
   parameter int CELL_LAT = 2
) (
   input logic                  clock,
   input logic                  reset,
   fb_cell_scanout_if.master    bus
);
   localparam int HW    = $clog2(H_TOTAL);
   localparam int VW    = $clog2(V_TOTAL);
   localparam int DEPTH = CELL_LAT + 1;

   typedef struct packed {
      logic       act;
      logic [2:0] x;
      logic [2:0] r;
      logic       hs;
      logic       vs;
      logic       vb;
   } tag_t;

   logic [HW-1:0] h_cnt_reg;
   logic [VW-1:0] v_cnt_reg;
   logic          h_last;
   logic          v_last;
   tag_t          tag_next;
   logic [13:0]   cell_ix_next;
   logic [13:0]   cell_ix_reg;

   assign h_last = (h_cnt_reg == HW'(H_TOTAL - 1));
   assign v_last = (v_cnt_reg == VW'(V_TOTAL - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         h_cnt_reg <= '0;
         v_cnt_reg <= '0;
      end else begin
         h_cnt_reg <= h_last ? '0 : h_cnt_reg + 1'b1;
         if (h_last)
            v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
      end
   end

   always_comb begin
      tag_next     = '0;
      tag_next.act = (h_cnt_reg < HW'(H_ACTIVE)) && (v_cnt_reg < VW'(V_ACTIVE));
      tag_next.x   = h_cnt_reg[2:0];
      tag_next.r   = v_cnt_reg[2:0];
      tag_next.hs  = (h_cnt_reg >= HW'(HS_START)) && (h_cnt_reg < HW'(HS_START + HS_LEN));
      tag_next.vs  = (v_cnt_reg >= VW'(VS_START)) && (v_cnt_reg < VW'(VS_START + VS_LEN));
      tag_next.vb  = (h_cnt_reg == '0) && (v_cnt_reg == VW'(V_ACTIVE));
      cell_ix_next = tag_next.act
                   ? 14'(v_cnt_reg >> 3) * 14'(CELLS_X) + 14'(h_cnt_reg >> 3)
                   : '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cell_ix_reg <= '0;
      else        cell_ix_reg <= cell_ix_next;
   end

   // Sideband delay line: the last stage lines up with the cell words fetched for its index.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         tag_t stage_reg;
         if (gi == 0) begin : g_first
            always_ff @(posedge clock or negedge reset) begin
               if (!reset) stage_reg <= '0;
               else        stage_reg <= tag_next;
            end
         end else begin : g_rest
            always_ff @(posedge clock or negedge reset) begin
               if (!reset) stage_reg <= '0;
               else        stage_reg <= g_stage[gi-1].stage_reg;
            end
         end
      end
   endgenerate

   tag_t        dec;
   logic [31:0] word;
   logic        pix_bit;
   logic [11:0] rgb_reg;
   logic        hsync_reg;
   logic        vsync_reg;
   logic        de_reg;
   logic        irq_reg;

   assign dec  = g_stage[DEPTH-1].stage_reg;
   assign word = dec.r[2] ? bus.cellData2 : bus.cellData1;
   // 31 - 8*r - x on 5 bits is simply the complement of {r[1:0], x}.
   assign pix_bit = word[~{dec.r[1:0], dec.x}];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rgb_reg   <= '0;
         hsync_reg <= 1'b1;
         vsync_reg <= 1'b1;
         de_reg    <= 1'b0;
         irq_reg   <= 1'b0;
      end else begin
         rgb_reg   <= (dec.act && bus.scrEnable) ? (pix_bit ? bus.fgColor : bus.bgColor) : '0;
         hsync_reg <= ~dec.hs;
         vsync_reg <= ~dec.vs;
         de_reg    <= dec.act;
         irq_reg   <= dec.vb;
      end
   end

   assign bus.pixCellIx = cell_ix_reg;
   assign bus.pixRgb    = rgb_reg;
   assign bus.pixHsync  = hsync_reg;
   assign bus.pixVsync  = vsync_reg;
   assign bus.pixDe     = de_reg;
   assign bus.irqVblank = irq_reg;
endmodule

// File: tb/tb_fb_cell_scanout.sv
// Directed bench for fb_cell_scanout with a shortened frame (16 active lines, 24 total).
`timescale 1ns/1ps
module tb_fb_cell_scanout;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   cyc   = 0;
   int   mode  = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [13:0] d1, d2;

   fb_cell_scanout_if bus();

   fb_cell_scanout #(
      .V_ACTIVE(16), .VS_START(20), .VS_LEN(2), .V_TOTAL(24)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Cell memory with 2 clocks of latency from index to data
   always @(posedge clock) begin
      d1 <= bus.pixCellIx;
      d2 <= d1;
   end
   assign bus.cellData1 = (mode == 0) ? 32'h8000_0000 : {32{d2[0]}};
   assign bus.cellData2 = (mode == 0) ? 32'h0000_0001 : {32{d2[0]}};

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      cyc = 0;
   endtask

   // Expected colour of raster position p (p = h + 400*v from the first clock after reset)
   function automatic logic [11:0] exp_pix(int p);
      int  h, v;
      logic b;
      if (p < 0) return 12'h000;
      h = p % 400;
      v = (p / 400) % 24;
      if (h >= 320 || v >= 16 || !bus.scrEnable) return 12'h000;
      if (mode == 0) b = ((h % 8 == 0) && (v % 8 == 0)) || ((h % 8 == 7) && (v % 8 == 7));
      else           b = ((((v / 8) * 40) + (h / 8)) % 2) == 1;
      return b ? bus.fgColor : bus.bgColor;
   endfunction

   task automatic test_reset();
      bus.scrEnable = 1'b1;
      bus.fgColor   = 12'hFFF;
      bus.bgColor   = 12'h000;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_tests++; if (bus.pixCellIx !== 14'd0) begin n_fail++; $display("FAIL reset_cellix got %0d want 0", bus.pixCellIx); end
      n_tests++; if (bus.pixRgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got %h want 000", bus.pixRgb); end
      n_tests++; if (bus.pixHsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got %b want 1", bus.pixHsync); end
      n_tests++; if (bus.pixVsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync got %b want 1", bus.pixVsync); end
      n_tests++; if (bus.pixDe !== 1'b0) begin n_fail++; $display("FAIL reset_de got %b want 0", bus.pixDe); end
      n_tests++; if (bus.irqVblank !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", bus.irqVblank); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_start();
      int first = -1, len = 0;
      logic [13:0] ix1 = '1, ix8 = '1, ix9 = '1;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         tick();
         if (cyc == 1) ix1 = bus.pixCellIx;
         if (cyc == 8) ix8 = bus.pixCellIx;
         if (cyc == 9) ix9 = bus.pixCellIx;
         if (bus.pixDe === 1'b1) begin
            if (first < 0) first = cyc;
            len++;
         end
      end
      n_tests++; if (ix1 !== 14'd0) begin n_fail++; $display("FAIL start_cellix_first got %0d want 0", ix1); end
      n_tests++; if (ix8 !== 14'd0) begin n_fail++; $display("FAIL start_cellix_h7 got %0d want 0", ix8); end
      n_tests++; if (ix9 !== 14'd1) begin n_fail++; $display("FAIL start_cellix_h8 got %0d want 1", ix9); end
      n_tests++; if (first !== 4) begin n_fail++; $display("FAIL start_de_first got %0d want 4", first); end
      n_tests++; if (len !== 320) begin n_fail++; $display("FAIL start_de_len got %0d want 320", len); end
      $display("[TB] test_start de_first=%0d de_len=%0d", first, len);
   endtask

   task automatic test_cell_index();
      int tv_h [8] = '{320, 16, 17, 23, 24, 17, 319, 5};
      int tv_v [8] = '{5,   9,  9,  9,  9,  15, 15,  16};
      int tv_e [8] = '{0,   42, 42, 42, 43, 42, 79,  0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         while (cyc < tv_v[i] * 400 + tv_h[i] + 1) tick();
         n_tests++;
         if (bus.pixCellIx !== 14'(tv_e[i])) begin
            n_fail++;
            $display("FAIL cell_index (%0d,%0d) got %0d want %0d", tv_h[i], tv_v[i], bus.pixCellIx, tv_e[i]);
         end else
            $display("[TB] cell_index (%0d,%0d) = %0d", tv_h[i], tv_v[i], bus.pixCellIx);
      end
   endtask

   task automatic test_decode();
      int bad, bad_p;
      logic [11:0] e, bad_got, bad_exp;
      for (int ph = 0; ph < 2; ph++) begin
         mode = ph;
         bus.scrEnable = 1'b1;
         bus.fgColor   = (ph == 0) ? 12'hFFF : 12'hA5C;
         bus.bgColor   = (ph == 0) ? 12'h000 : 12'h3C1;
         do_reset();
         for (int ln = 0; ln < ((ph == 0) ? 10 : 3); ln++) begin
            bad = 0; bad_p = 0; bad_got = '0; bad_exp = '0;
            for (int k = 0; k < 400; k++) begin
               tick();
               e = exp_pix(cyc - 4);
               if (bus.pixRgb !== e) begin
                  if (bad == 0) begin bad_p = cyc - 4; bad_got = bus.pixRgb; bad_exp = e; end
                  bad++;
               end
               // colour change lands on the very next pixel
               if (ph == 1 && cyc == 500) bus.bgColor = 12'h777;
            end
            n_tests++;
            if (bad != 0) begin
               n_fail++;
               $display("FAIL decode mode%0d line%0d: %0d bad, first pos %0d got %h want %h",
                        ph, ln, bad, bad_p, bad_got, bad_exp);
            end else
               $display("[TB] decode mode%0d line%0d ok", ph, ln);
         end
      end
   endtask

   task automatic test_sync();
      logic ph = 1'b1, pv = 1'b1, pi = 1'b0;
      int hs_fall1 = -1, hs_fall2 = -1, hs_len = 0, hs_n = 0;
      int vs_fall1 = -1, vs_len = 0, vs_n = 0;
      int irq1 = -1, irq2 = -1, irq_n = 0, irq_wide = 0, de_n = 0;
      mode = 0;
      bus.scrEnable = 1'b1;
      do_reset();
      for (int k = 0; k < 16010; k++) begin
         tick();
         if (ph && !bus.pixHsync) begin
            hs_n++;
            if (hs_n == 1) hs_fall1 = cyc;
            if (hs_n == 2) hs_fall2 = cyc;
         end
         if (!bus.pixHsync && hs_n == 1) hs_len++;
         if (pv && !bus.pixVsync) begin
            vs_n++;
            if (vs_n == 1) vs_fall1 = cyc;
         end
         if (!bus.pixVsync && vs_n == 1) vs_len++;
         if (bus.irqVblank) begin
            if (pi) irq_wide++;
            else begin
               irq_n++;
               if (irq_n == 1) irq1 = cyc;
               if (irq_n == 2) irq2 = cyc;
            end
         end
         if (bus.pixDe && cyc <= 9603) de_n++;
         ph = bus.pixHsync; pv = bus.pixVsync; pi = bus.irqVblank;
      end
      n_tests++; if (hs_fall1 !== 332) begin n_fail++; $display("FAIL hsync_start got %0d want 332", hs_fall1); end
      n_tests++; if (hs_len !== 48) begin n_fail++; $display("FAIL hsync_len got %0d want 48", hs_len); end
      n_tests++; if (hs_fall2 - hs_fall1 !== 400) begin n_fail++; $display("FAIL hsync_period got %0d want 400", hs_fall2 - hs_fall1); end
      n_tests++; if (vs_fall1 !== 8004) begin n_fail++; $display("FAIL vsync_start got %0d want 8004", vs_fall1); end
      n_tests++; if (vs_len !== 800) begin n_fail++; $display("FAIL vsync_len got %0d want 800", vs_len); end
      n_tests++; if (irq1 !== 6404) begin n_fail++; $display("FAIL irq_first got %0d want 6404", irq1); end
      n_tests++; if (irq2 - irq1 !== 9600) begin n_fail++; $display("FAIL frame_period got %0d want 9600", irq2 - irq1); end
      n_tests++; if (irq_n !== 2) begin n_fail++; $display("FAIL irq_count got %0d want 2", irq_n); end
      n_tests++; if (irq_wide !== 0) begin n_fail++; $display("FAIL irq_width extra high clocks got %0d want 0", irq_wide); end
      n_tests++; if (de_n !== 5120) begin n_fail++; $display("FAIL de_per_frame got %0d want 5120", de_n); end
      $display("[TB] test_sync hs=%0d/%0d vs=%0d/%0d irq=%0d,%0d", hs_fall1, hs_len, vs_fall1, vs_len, irq1, irq2);
   endtask

   task automatic test_scr_enable();
      logic [2:0] ref_t [800];
      int diffs = 0, nz = 0;
      logic [11:0] rgb100 = '0, rgb201 = '0;
      mode = 1;
      bus.fgColor = 12'hA5C;
      bus.bgColor = 12'h3C1;
      bus.scrEnable = 1'b1;
      do_reset();
      for (int k = 0; k < 800; k++) begin
         tick();
         ref_t[k] = {bus.pixDe, bus.pixHsync, bus.pixVsync};
      end
      do_reset();
      for (int k = 0; k < 800; k++) begin
         tick();
         if ({bus.pixDe, bus.pixHsync, bus.pixVsync} !== ref_t[k]) diffs++;
         if (cyc == 100) rgb100 = bus.pixRgb;
         if (cyc >= 101 && cyc <= 200 && bus.pixRgb !== 12'h000) nz++;
         if (cyc == 201) rgb201 = bus.pixRgb;
         if (cyc == 100) bus.scrEnable = 1'b0;
         if (cyc == 200) bus.scrEnable = 1'b1;
      end
      n_tests++; if (rgb100 !== 12'h3C1) begin n_fail++; $display("FAIL scr_before got %h want 3c1", rgb100); end
      n_tests++; if (nz !== 0) begin n_fail++; $display("FAIL scr_blank nonzero pixels got %0d want 0", nz); end
      n_tests++; if (rgb201 !== 12'h3C1) begin n_fail++; $display("FAIL scr_after got %h want 3c1", rgb201); end
      n_tests++; if (diffs !== 0) begin n_fail++; $display("FAIL scr_timing differing clocks got %0d want 0", diffs); end
      $display("[TB] test_scr_enable blank_nonzero=%0d timing_diffs=%0d", nz, diffs);
   endtask

   task automatic test_mid_reset();
      int first = -1, len = 0;
      logic [13:0] ix1 = '1, ix20 = '1;
      mode = 1;
      bus.scrEnable = 1'b1;
      do_reset();
      while (cyc < 150) tick();
      #2;
      reset = 1'b0;
      #1;
      n_tests++; if (bus.pixCellIx !== 14'd0) begin n_fail++; $display("FAIL midreset_cellix got %0d want 0", bus.pixCellIx); end
      n_tests++; if (bus.pixDe !== 1'b0) begin n_fail++; $display("FAIL midreset_de got %b want 0", bus.pixDe); end
      n_tests++; if (bus.pixRgb !== 12'h000) begin n_fail++; $display("FAIL midreset_rgb got %h want 000", bus.pixRgb); end
      n_tests++; if (bus.pixHsync !== 1'b1 || bus.pixVsync !== 1'b1) begin n_fail++; $display("FAIL midreset_sync got %b%b want 11", bus.pixHsync, bus.pixVsync); end
      @(negedge clock);
      reset = 1'b1;
      cyc = 0;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (cyc == 1)  ix1  = bus.pixCellIx;
         if (cyc == 20) ix20 = bus.pixCellIx;
         if (bus.pixDe === 1'b1) begin
            if (first < 0) first = cyc;
            len++;
         end
      end
      n_tests++; if (ix1 !== 14'd0) begin n_fail++; $display("FAIL midreset_cellix_first got %0d want 0", ix1); end
      n_tests++; if (ix20 !== 14'd2) begin n_fail++; $display("FAIL midreset_cellix_h19 got %0d want 2", ix20); end
      n_tests++; if (first !== 4) begin n_fail++; $display("FAIL midreset_de_first got %0d want 4", first); end
      n_tests++; if (len !== 320) begin n_fail++; $display("FAIL midreset_de_len got %0d want 320", len); end
      $display("[TB] test_mid_reset de_first=%0d de_len=%0d", first, len);
   endtask

   initial begin
      test_reset();
      test_start();
      test_cell_index();
      test_decode();
      test_sync();
      test_scr_enable();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fb_cell_scanout.md
Name: fb_cell_scanout

Overview:
- Video scanout engine; reads the framebuffer cell memory through its pixel-side port.
- Generates raster timing and drives the cell index. Decodes the returned 64-bit cells, 8x8 pixels at 1 bpp, into RGB pixels with sync and data-enable signals.
- Emits a once-per-frame vblank pulse so the screen-update ISR can rewrite cell memory outside active display.

Parameters:
- H_ACTIVE, 320, visible pixels per line; must be a multiple of 8.
- HS_START, 328, first hCnt of hsync.
- HS_LEN, 48, hsync width in clocks.
- H_TOTAL, 400, clocks per line.
- V_ACTIVE, 200, visible lines; must be a multiple of 8.
- VS_START, 212, first vCnt of vsync.
- VS_LEN, 2, vsync width in lines.
- V_TOTAL, 262, lines per frame.
- CELLS_X, 40, cells per row; equals H_ACTIVE/8.
- CELL_LAT, 2, clocks from pixCellIx change to matching cellData1/2.

Ports:
- clock  in  1  system clock, one pixel per clock.
- reset  in  1  asynchronous, active-low reset.
- pixCellIx  out  14  cell index presented to the cell memory.
- cellData1  in  32  cell word A: glyph rows 0-3.
- cellData2  in  32  cell word B: glyph rows 4-7.
- scrEnable  in  1  display enable; 0 blanks the RGB output only.
- fgColor  in  12  foreground RGB444.
- bgColor  in  12  background RGB444.
- pixRgb  out  12  pixel colour.
- pixHsync  out  1  horizontal sync, active-low.
- pixVsync  out  1  vertical sync, active-low.
- pixDe  out  1  data enable, high in the active region.
- irqVblank  out  1  one-clock vblank pulse.

Behaviour:
- Reset (reset=0, asynchronous, takes effect without a clock edge):
  - hCnt=0, vCnt=0, all pipeline stages cleared.
  - pixCellIx=0, pixRgb=0, pixHsync=1, pixVsync=1, pixDe=0, irqVblank=0.
  - Mid-frame reset aborts the frame. The first clock after release is counter position (0,0).
- Counters:
  - hCnt runs 0..H_TOTAL-1 and wraps to 0.
  - When hCnt wraps, vCnt increments. vCnt wraps from V_TOTAL-1 to 0.
  - Free-running, independent of scrEnable.
- Active region: act = (hCnt<H_ACTIVE) && (vCnt<V_ACTIVE).
- Cell index:
  - Registered every clock.
  - pixCellIx <= act ? (vCnt>>3)*CELLS_X + (hCnt>>3) : 0.
  - Arithmetic is 14-bit unsigned with no overflow for the defaults; maximum index is 999.
- Pipeline:
  - A delay line carries act, hCnt[2:0], vCnt[2:0], hsync and vsync flags, and the vblank-start flag.
  - Depth is CELL_LAT+1, so cellData aligns with the stage that issued pixCellIx.
  - One more output register follows.
  - All outputs therefore lag the counters by exactly CELL_LAT+2 clocks (4 at default). No other latency is permitted.
- Decode, at the aligned stage with r=row-in-cell and x=column-in-cell:
  - For r<4: bit = cellData1[31-8r-x].
  - Otherwise: bit = cellData2[31-8(r-4)-x].
  - Bit 31 of each word is the top-left pixel of its half.
- Output:
  - pixRgb = (de && scrEnable) ? (bit ? fgColor : bgColor) : 0.
  - fgColor and bgColor are sampled at the decode stage; a change takes effect on the next pixel.
- Syncs:
  - hsync flag true when HS_START <= hCnt < HS_START+HS_LEN.
  - vsync flag true when VS_START <= vCnt < VS_START+VS_LEN.
  - pixHsync and pixVsync are the inverted, delayed flags.
- irqVblank:
  - Flag true only at counter position (hCnt=0, vCnt=V_ACTIVE).
  - Delayed like the other outputs: exactly one pulse per frame, one clock wide.
- Boundaries:
  - Line wrap and frame wrap are seamless; there is no dead cycle between lines or frames.
  - scrEnable toggling mid-line affects pixRgb from the next clock's decode only. Timing outputs are unaffected.
  - cellData contents outside the active region are ignored.

Test Plan:
- Reset release, then track pixCellIx -> counter (0,0) gives pixCellIx=0 one clock after release. pixDe first goes high 4 clocks after counter (0,0) and stays high 320 clocks.
- Cell indexing -> counter (17,9) gives pixCellIx=42; (319,199) gives 999; (320,5) gives 0. Index is constant across each 8-pixel run and repeats for all 8 lines of a cell row.
- Decode with a memory model of latency 2 returning cellData1=0x80000000, cellData2=0x00000001, fgColor=0xFFF, bgColor=0x000:
  - Only pixel (0,0) and pixel (7,7) of each cell output 0xFFF.
  - All other active pixels output 0x000.
  - Blanking outputs 0.
- Sync/frame timing:
  - pixHsync low exactly 48 consecutive clocks per line, 400-clock period.
  - pixVsync low exactly 800 clocks.
  - Frame period 104800 clocks.
  - irqVblank high exactly once per frame, 4 clocks after counter (0,200).
- scrEnable=0 mid-line -> pixRgb=0 from the next pixel; pixDe, pixHsync and pixVsync remain bit-identical to a scrEnable=1 run.
- Assert reset mid-line with no clock edge -> all outputs at reset values immediately. After release, the timing sequence matches the first scenario.
